// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared register map, STAT layout, FSM states and entry type for the LCD controller
package lcd_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_CMD  = 2'd1;
    localparam logic [1:0] REG_STAT = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_FULL  = 2;
    localparam int STAT_OVF   = 3;
    localparam int STAT_COUNT = 8;

    localparam logic RS_DATA = 1'b1;
    localparam logic RS_CMD  = 1'b0;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_WAIT  = 3'd4
    } lcd_state_e;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_entry_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear-display and return-home need milliseconds on the panel side.
    function automatic logic is_slow_cmd(input lcd_entry_t e);
        return (e.rs == RS_CMD) && ((e.data == CMD_CLEAR) || (e.data == CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_mmio_ctrl_if.sv
// rtl/lcd_mmio_ctrl_if.sv - CPU peripheral bus bundle for the LCD controller
interface lcd_mmio_ctrl_if;
    logic        bus_sel;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wenable;
    logic [31:0] bus_rdata;

    modport master (
        output bus_sel, bus_addr, bus_wdata, bus_wenable,
        input  bus_rdata
    );

    modport slave (
        input  bus_sel, bus_addr, bus_wdata, bus_wenable,
        output bus_rdata
    );
endinterface

// File: rtl/lcd_tx_fifo.sv
// rtl/lcd_tx_fifo.sv - synchronous TX FIFO of {RS, data} entries with push/pop/flush and occupancy count
module lcd_tx_fifo
    import lcd_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  lcd_entry_t    push_data,
    input  logic          pop,
    input  logic          flush,
    output lcd_entry_t    pop_data,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    lcd_entry_t    mem_q [DEPTH];
    lcd_entry_t    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A flush also discards a same-cycle push; the head being popped is already taken.
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push_ok);
            rd_ptr_d = rd_ptr_q + AW'(pop_ok);
            count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/lcd_mmio_ctrl.sv
// rtl/lcd_mmio_ctrl.sv - memory-mapped HD44780 write controller: register decode, TX FIFO, timed E-strobe FSM
// Optional LCD_LONG_CMD_EN adds a post-hold WAIT of LONG_CYC cycles after clear/home commands.
module lcd_mmio_ctrl
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int SETUP_CYC  = 2,
    parameter int PULSE_CYC  = 8,
    parameter int HOLD_CYC   = 16,
    parameter int LONG_CYC   = 2000
) (
    input  logic                  clk,
    input  logic                  rst,
    lcd_mmio_ctrl_if.slave        bus,
    output logic [7:0]            lcd_data,
    output logic [1:0]            lcd_ctrl,
    output logic                  lcd_enable
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef LCD_LONG_CMD_EN
    localparam int TMAX = max_int(max_int(SETUP_CYC, PULSE_CYC), max_int(HOLD_CYC, LONG_CYC));
`else
    localparam int TMAX = max_int(max_int(SETUP_CYC, PULSE_CYC), HOLD_CYC);
    localparam int long_cyc_unused = LONG_CYC;
`endif
    localparam int CNT_W = $clog2(TMAX) + 1;

    logic          wr_en;
    logic          push;
    logic          flush;
    logic          ovf_clr;
    lcd_entry_t    push_data;
    lcd_entry_t    head;
    logic          pop;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic [31:0]   stat;
    logic          unused_bus_bits;

    lcd_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d;
    logic          en_q, en_d;
    logic          ovf_q, ovf_d;

    assign wr_en   = bus.bus_sel & bus.bus_wenable[0];
    assign push    = wr_en & ((bus.bus_addr == REG_DATA) | (bus.bus_addr == REG_CMD));
    assign flush   = wr_en & (bus.bus_addr == REG_CTRL) & bus.bus_wdata[0];
    assign ovf_clr = wr_en & (bus.bus_addr == REG_CTRL) & bus.bus_wdata[1];
    assign push_data.rs   = (bus.bus_addr == REG_DATA) ? RS_DATA : RS_CMD;
    assign push_data.data = bus.bus_wdata[7:0];
    assign unused_bus_bits = ^{bus.bus_wdata[31:8], bus.bus_wenable[3:1]};

    lcd_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .pop_data  (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Overflow uses the pre-edge full flag, so a pop in the same cycle does not save the push.
    always_comb begin
        ovf_d = ovf_q;
        if (push & fifo_full & ~flush) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rs_d    = rs_q;
        en_d    = en_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    data_d  = head.data;
                    rs_d    = head.rs;
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    en_d    = 1'b1;
                    cnt_d   = CNT_W'(PULSE_CYC - 1);
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    en_d    = 1'b0;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
`ifdef LCD_LONG_CMD_EN
                    if (is_slow_cmd({rs_q, data_q})) begin
                        cnt_d   = CNT_W'(LONG_CYC - 1);
                        state_d = ST_WAIT;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef LCD_LONG_CMD_EN
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            default: begin
                en_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            ovf_q   <= ovf_d;
        end
    end

    assign lcd_data   = data_q;
    assign lcd_ctrl   = {rs_q, 1'b0};
    assign lcd_enable = en_q;

    always_comb begin
        stat                     = '0;
        stat[STAT_BUSY]          = (state_q != ST_IDLE);
        stat[STAT_EMPTY]         = fifo_empty;
        stat[STAT_FULL]          = fifo_full;
        stat[STAT_OVF]           = ovf_q;
        stat[STAT_COUNT +: CW]   = fifo_count;
    end

    always_comb begin
        bus.bus_rdata = '0;
        if (bus.bus_sel && (bus.bus_addr == REG_STAT)) begin
            bus.bus_rdata = stat;
        end
    end

endmodule

// File: tb/tb_lcd_mmio_ctrl.sv
// tb/tb_lcd_mmio_ctrl.sv - self-checking bench for lcd_mmio_ctrl: register vectors, timing sequences, randomized traffic vs a timeline model
module tb_lcd_mmio_ctrl;

    localparam int D = 8;
    localparam int S = 2;
    localparam int P = 8;
    localparam int H = 16;
    localparam int L = 2000;
`ifdef LCD_LONG_CMD_EN
    localparam int LX = L;
`else
    localparam int LX = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] lcd_data;
    logic [1:0] lcd_ctrl;
    logic       lcd_enable;

    always #5 clk = ~clk;

    lcd_mmio_ctrl_if bus ();

    lcd_mmio_ctrl #(
        .FIFO_DEPTH (D),
        .SETUP_CYC  (S),
        .PULSE_CYC  (P),
        .HOLD_CYC   (H),
        .LONG_CYC   (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .lcd_data   (lcd_data),
        .lcd_ctrl   (lcd_ctrl),
        .lcd_enable (lcd_enable)
    );

    typedef struct {
        logic       rs;
        logic [7:0] data;
    } ent_t;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         rise;
    } pulse_t;

    typedef struct {
        logic        sel;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [3:0]  we;
        logic [31:0] exp_rd;
    } vec_t;

    ent_t   pend_q[$];
    pulse_t exp_q[$];
    int     rises[$];
    int     falls[$];
    int     e         = 0;
    int     next_free = 0;
    bit     m_ovf     = 1'b0;
    bit     mon_rst   = 1'b0;
    bit     in_pulse  = 1'b0;
    int     rise_e    = 0;
    pulse_t mon_p;
    int     checks    = 0;
    int     errors    = 0;
    vec_t   vt[9];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h (edge %0d)", name, got, exp, e);
        end
    endtask

    function automatic bit slow(input ent_t x);
        return (LX != 0) && !x.rs && ((x.data == 8'h01) || (x.data == 8'h02));
    endfunction

    // Timeline model: an entry leaves the queue at the first edge where the engine is free.
    task automatic model_edge(input logic r, input logic sel, input logic [1:0] a,
                              input logic [31:0] wd, input logic [3:0] we);
        int   sz;
        ent_t x;
        if (r) begin
            pend_q.delete();
            exp_q.delete();
            m_ovf     = 1'b0;
            next_free = 0;
            mon_rst   = 1'b1;
            return;
        end
        sz = pend_q.size();
        if (sz > 0 && e >= next_free) begin
            x = pend_q.pop_front();
            exp_q.push_back('{x.rs, x.data, e + S});
            next_free = e + S + P + H + 1 + (slow(x) ? LX : 0);
        end
        if (sel && we[0]) begin
            if (a == 2'd0 || a == 2'd1) begin
                if (sz == D) m_ovf = 1'b1;
                else pend_q.push_back('{(a == 2'd0), wd[7:0]});
            end else if (a == 2'd3) begin
                if (wd[0]) pend_q.delete();
                if (wd[1]) m_ovf = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] model_stat();
        int sz;
        sz = pend_q.size();
        return (32'(sz) << 8) | (32'(m_ovf) << 3) | (32'(sz == D) << 2)
             | (32'(sz == 0) << 1) | 32'(e < next_free - 1);
    endfunction

    task automatic cycle(input logic r, input logic sel, input logic [1:0] a,
                         input logic [31:0] wd, input logic [3:0] we);
        rst             = r;
        bus.bus_sel     = sel;
        bus.bus_addr    = a;
        bus.bus_wdata   = wd;
        bus.bus_wenable = we;
        @(posedge clk);
        e++;
        model_edge(r, sel, a, wd, we);
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cycle(1'b0, 1'b1, a, {24'h0, d}, 4'h1);
    endtask

    task automatic read_stat(output logic [31:0] v);
        bus.bus_sel     = 1'b1;
        bus.bus_addr    = 2'd2;
        bus.bus_wenable = 4'h0;
        #1;
        v = bus.bus_rdata;
        bus.bus_sel = 1'b0;
    endtask

    task automatic check_stat(input string name);
        logic [31:0] v;
        read_stat(v);
        chk(name, v, model_stat());
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(pend_q.size() == 0 && e >= next_free && !in_pulse) && n < 20000) begin
            idle();
            n++;
        end
        chk("drain_timeout", 64'(n >= 20000), 0);
        repeat (2) idle();
        chk("drain_leftover", exp_q.size(), 0);
    endtask

    task automatic wait_enable();
        int n;
        n = 0;
        while (!lcd_enable && n < 200) begin
            idle();
            n++;
        end
        chk("wait_enable", lcd_enable, 1);
    endtask

    always @(negedge clk) begin
        if (mon_rst) begin
            mon_rst  = 1'b0;
            in_pulse = 1'b0;
        end else if (lcd_enable && !in_pulse) begin
            in_pulse = 1'b1;
            rise_e   = e;
        end else if (!lcd_enable && in_pulse) begin
            in_pulse = 1'b0;
            rises.push_back(rise_e);
            falls.push_back(e);
            if (exp_q.size() == 0) begin
                chk("spurious_pulse", 1, 0);
            end else begin
                mon_p = exp_q.pop_front();
                chk("pulse", {lcd_ctrl, lcd_data, 24'(rise_e), 16'(e - rise_e)},
                    {mon_p.rs, 1'b0, mon_p.data, 24'(mon_p.rise), 16'(P)});
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at edge %0d", e);
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int          w;
        int          r;

        vt[0] = '{1'b1, 2'd2, 32'h0,  4'h0, 32'h2};
        vt[1] = '{1'b0, 2'd2, 32'h0,  4'h0, 32'h0};
        vt[2] = '{1'b1, 2'd0, 32'h0,  4'h0, 32'h0};
        vt[3] = '{1'b1, 2'd1, 32'h0,  4'h0, 32'h0};
        vt[4] = '{1'b1, 2'd3, 32'h0,  4'h0, 32'h0};
        vt[5] = '{1'b1, 2'd0, 32'h55, 4'hE, 32'h0};
        vt[6] = '{1'b0, 2'd0, 32'h55, 4'h1, 32'h0};
        vt[7] = '{1'b1, 2'd3, 32'h3,  4'h1, 32'h0};
        vt[8] = '{1'b1, 2'd2, 32'hFF, 4'hF, 32'h2};

        rst = 1'b1;
        bus.bus_sel = 1'b0; bus.bus_addr = 2'd0; bus.bus_wdata = '0; bus.bus_wenable = '0;
        @(negedge clk);
        repeat (3) cycle(1'b1, 1'b0, 2'd0, 32'h0, 4'h0);
        chk("reset_enable", lcd_enable, 0);
        chk("reset_data", lcd_data, 0);
        chk("reset_ctrl", lcd_ctrl, 0);
        read_stat(v);
        chk("reset_stat", v, 32'h2);
        idle();

        for (int i = 0; i < 9; i++) begin
            bus.bus_sel = vt[i].sel; bus.bus_addr = vt[i].addr;
            bus.bus_wdata = vt[i].wd; bus.bus_wenable = vt[i].we;
            #1;
            chk($sformatf("vec%0d_rdata", i), bus.bus_rdata, vt[i].exp_rd);
            cycle(1'b0, vt[i].sel, vt[i].addr, vt[i].wd, vt[i].we);
            check_stat($sformatf("vec%0d_stat", i));
        end
        chk("vec_no_pulse", rises.size(), 0);

        rises.delete(); falls.delete();
        wr(2'd0, 8'h41);
        w = e;
        drain();
        chk("t1_count", rises.size(), 1);
        if (rises.size() == 1) begin
            chk("t1_latency", rises[0] - w, S + 1);
            chk("t1_width", falls[0] - rises[0], P);
        end

        rises.delete(); falls.delete();
        wr(2'd1, 8'h38); wr(2'd0, 8'h48); wr(2'd0, 8'h69);
        drain();
        chk("t2_count", rises.size(), 3);
        if (rises.size() == 3) begin
            chk("t2_gap1", rises[1] - falls[0], H + 1 + S);
            chk("t2_gap2", rises[2] - falls[1], H + 1 + S);
        end

        for (int i = 0; i < 10; i++) wr(2'd0, 8'h30 + 8'(i));
        read_stat(v);
        chk("t3_full_ovf", v, 32'h80D);
        check_stat("t3_model");
        wr(2'd3, 8'h02);
        read_stat(v);
        chk("t3_ovf_clear", v, 32'h805);
        wr(2'd3, 8'h01);
        check_stat("t3_flush");
        drain();

        rises.delete(); falls.delete();
        wr(2'd0, 8'hA1); wr(2'd0, 8'hA2); wr(2'd0, 8'hA3);
        wait_enable();
        wr(2'd3, 8'h01);
        check_stat("t4_after_flush");
        drain();
        chk("t4_count", rises.size(), 1);
        read_stat(v);
        chk("t4_idle_stat", v, 32'h2);

        wr(2'd0, 8'h5A); wr(2'd0, 8'h5B);
        wait_enable();
        cycle(1'b1, 1'b0, 2'd0, 32'h0, 4'h0);
        chk("t5_enable", lcd_enable, 0);
        chk("t5_data", lcd_data, 0);
        chk("t5_ctrl", lcd_ctrl, 0);
        read_stat(v);
        chk("t5_stat", v, 32'h2);
        rises.delete(); falls.delete();
        idle();
        drain();
        chk("t5_no_resume", rises.size(), 0);

        rises.delete(); falls.delete();
        wr(2'd1, 8'h01); wr(2'd0, 8'h41);
        drain();
        chk("t6_count", rises.size(), 2);
        if (rises.size() == 2) chk("t6_gap", rises[1] - falls[0], H + 1 + S + LX);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 20)      wr(2'd0, 8'($urandom_range(0, 255)));
            else if (r < 30) wr(2'd1, 8'($urandom_range(0, 255)));
            else if (r < 33) cycle(1'b0, 1'b1, 2'd3, 32'($urandom_range(0, 3)), 4'h1);
            else if (r < 36) cycle(1'b0, 1'b1, 2'($urandom_range(0, 3)), $urandom,
                                   4'($urandom_range(0, 15)) & 4'hE);
            else             idle();
            check_stat("rand_stat");
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
